// File: rtl/audio_pkg.sv
// Shared types and constants for the audio playback scheduler.
package audio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    OUT_FIRST,
    OUT_SECOND
  } sched_state_t;

  localparam int DIV_MIN  = 1;
  localparam int SAMPLE_W = 16;
  localparam int WORD_W   = 32;

  localparam logic [22:0] END_ADDR_DEF = 23'h7FFFF;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate tick from a signed divider; the count freezes (not clears) while en=0.
module sample_tick_gen
  import audio_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic signed [31:0] div_clk_count,
  output logic               tick
);

  logic [31:0] r_cnt;
  logic [31:0] w_period;

  // Zero or negative dividers clamp to one tick per cycle.
  assign w_period = (div_clk_count < DIV_MIN) ? 32'(DIV_MIN) : div_clk_count;
  assign tick     = en && (r_cnt >= (w_period - 32'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/audio_sample_scheduler.sv
// Fetches 32-bit flash words and plays them out as two 16-bit samples per word,
// one sample per tick, with pause, direction, restart and underrun handling.
module audio_sample_scheduler
  import audio_pkg::*;
#(
  parameter int                ADDR_W   = 23,
  parameter logic [ADDR_W-1:0] END_ADDR = ADDR_W'(END_ADDR_DEF)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [31:0]  div_clk_count,
  input  logic                play,
  input  logic                dir_fwd,
  input  logic                restart,
  output logic                flash_read,
  output logic [ADDR_W-1:0]   flash_addr,
  input  logic                flash_waitrequest,
  input  logic                flash_readdatavalid,
  input  logic [WORD_W-1:0]   flash_readdata,
  output logic [SAMPLE_W-1:0] audio_data,
  output logic                audio_valid,
  output logic                underrun
);

  sched_state_t        r_state;
  logic                r_flash_read;
  logic [ADDR_W-1:0]   r_flash_addr;
  logic [SAMPLE_W-1:0] r_audio_data;
  logic                r_audio_valid;
  logic                r_underrun;
  logic [WORD_W-1:0]   r_word;
  logic                r_hi_first;
  logic                r_restart_pending;

  logic              w_tick;
  logic              w_restart_now;
  logic              w_tick_rst;
  logic [ADDR_W-1:0] w_start_addr;
  logic [ADDR_W-1:0] w_next_addr;

  assign w_start_addr = dir_fwd ? '0 : END_ADDR;
  assign w_next_addr  = dir_fwd
                        ? ((r_flash_addr == END_ADDR) ? '0 : r_flash_addr + ADDR_W'(1))
                        : ((r_flash_addr == '0) ? END_ADDR : r_flash_addr - ADDR_W'(1));

  // A bus read is never aborted: restart during REQ/WAIT_DATA waits for the data beat.
  always_comb begin
    w_restart_now = 1'b0;
    case (r_state)
      IDLE, OUT_FIRST, OUT_SECOND: w_restart_now = restart;
      WAIT_DATA: w_restart_now = flash_readdatavalid && (restart || r_restart_pending);
      default:   w_restart_now = 1'b0;
    endcase
  end

  assign w_tick_rst = rst | w_restart_now;

  sample_tick_gen u_tick (
    .clk           (clk),
    .rst           (w_tick_rst),
    .en            (play),
    .div_clk_count (div_clk_count),
    .tick          (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= IDLE;
      r_flash_read      <= 1'b0;
      r_flash_addr      <= '0;
      r_audio_data      <= '0;
      r_audio_valid     <= 1'b0;
      r_underrun        <= 1'b0;
      r_word            <= '0;
      r_hi_first        <= 1'b0;
      r_restart_pending <= 1'b0;
    end else begin
      r_audio_valid <= 1'b0;
      if (w_restart_now) begin
        r_flash_addr      <= w_start_addr;
        r_underrun        <= 1'b0;
        r_restart_pending <= 1'b0;
        r_flash_read      <= play;
        r_state           <= play ? REQ : IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (play) begin
              r_flash_read <= 1'b1;
              r_state      <= REQ;
            end
          end
          REQ: begin
            if (restart) r_restart_pending <= 1'b1;
            if (w_tick)  r_underrun        <= 1'b1;
            if (!flash_waitrequest) begin
              r_flash_read <= 1'b0;
              r_state      <= WAIT_DATA;
            end
          end
          WAIT_DATA: begin
            if (restart) r_restart_pending <= 1'b1;
            if (w_tick)  r_underrun        <= 1'b1;
            if (flash_readdatavalid) begin
              r_word     <= flash_readdata;
              r_hi_first <= !dir_fwd;
              r_state    <= OUT_FIRST;
            end
          end
          OUT_FIRST: begin
            if (w_tick) begin
              r_audio_data  <= r_hi_first ? r_word[WORD_W-1:SAMPLE_W] : r_word[SAMPLE_W-1:0];
              r_audio_valid <= 1'b1;
              r_state       <= OUT_SECOND;
            end
          end
          OUT_SECOND: begin
            if (w_tick) begin
              r_audio_data  <= r_hi_first ? r_word[SAMPLE_W-1:0] : r_word[WORD_W-1:SAMPLE_W];
              r_audio_valid <= 1'b1;
              r_flash_addr  <= w_next_addr;
              r_flash_read  <= 1'b1;
              r_state       <= REQ;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign flash_read  = r_flash_read;
  assign flash_addr  = r_flash_addr;
  assign audio_data  = r_audio_data;
  assign audio_valid = r_audio_valid;
  assign underrun    = r_underrun;

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Scoreboard bench: stimulus queues expected samples/addresses, monitor and flash model check them.
module tb_audio_sample_scheduler;

  localparam logic [22:0] END_A  = 23'h7FFFF;
  localparam logic [22:0] END_M1 = 23'h7FFFE;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [31:0] div_clk_count = 32'sd4;
  logic               play = 1'b0;
  logic               dir_fwd = 1'b1;
  logic               restart = 1'b0;
  logic               flash_read;
  logic [22:0]        flash_addr;
  logic               flash_waitrequest = 1'b0;
  logic               flash_readdatavalid = 1'b0;
  logic [31:0]        flash_readdata = 32'h0;
  logic [15:0]        audio_data;
  logic               audio_valid;
  logic               underrun;

  typedef struct {
    logic [15:0] data;
    int          gap;
  } exp_t;

  exp_t        exp_q[$];
  logic [22:0] exp_addr[$];
  int errors = 0, checks = 0, cyc = 0;
  int stall_add = 0, stall_done = 0, poison_req = 0, poison_done = 0, inj_req = 0, inj_done = 0;

  audio_sample_scheduler dut (
    .clk                 (clk),
    .rst                 (rst),
    .div_clk_count       (div_clk_count),
    .play                (play),
    .dir_fwd             (dir_fwd),
    .restart             (restart),
    .flash_read          (flash_read),
    .flash_addr          (flash_addr),
    .flash_waitrequest   (flash_waitrequest),
    .flash_readdatavalid (flash_readdatavalid),
    .flash_readdata      (flash_readdata),
    .audio_data          (audio_data),
    .audio_valid         (audio_valid),
    .underrun            (underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] word_at(input logic [22:0] a);
    return {a[15:0] ^ 16'hBBBB, a[15:0] ^ 16'hAAAA};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_a(input logic [15:0] d, input int g);
    exp_t e;
    e.data = d;
    e.gap  = g;
    exp_q.push_back(e);
  endtask

  task automatic wait_le(input int n, input string name);
    int k = 0;
    while (exp_q.size() > n && k < 300) begin
      step();
      k++;
    end
    chk(name, 32'(exp_q.size() > n), 32'd0);
  endtask

  // Monitor: every audio_valid pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    int   last = 0;
    forever begin
      @(negedge clk);
      if (audio_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got sample %h, expected none", audio_data);
        end else begin
          e = exp_q.pop_front();
          chk("audio_data", 32'(audio_data), 32'(e.data));
          if (e.gap != 0) chk("sample_gap", 32'(cyc - last), 32'(e.gap));
        end
        last = cyc;
      end
    end
  end

  // Flash model: one-cycle read latency, optional stalls, poisoned or stale beats.
  initial begin
    logic        acc;
    logic [22:0] a;
    forever begin
      @(negedge clk);
      acc = flash_read && !flash_waitrequest && !rst;
      a   = flash_addr;
      @(posedge clk);
      #1;
      flash_readdatavalid = 1'b0;
      if (acc) begin
        flash_readdatavalid = 1'b1;
        if (poison_done < poison_req) begin
          flash_readdata = 32'hDEAD_BEEF;
          poison_done++;
        end else begin
          flash_readdata = word_at(a);
        end
        if (exp_addr.size() > 0) chk("read_addr", 32'(a), 32'(exp_addr.pop_front()));
      end else if (inj_done < inj_req) begin
        flash_readdatavalid = 1'b1;
        flash_readdata      = 32'h1234_5678;
        inj_done++;
      end
      flash_waitrequest = flash_read && (stall_done < stall_add);
      if (flash_waitrequest) stall_done++;
    end
  end

  initial begin
    int n;
    step(3);
    chk("rst_flash_read", 32'(flash_read), 32'd0);
    chk("rst_flash_addr", 32'(flash_addr), 32'd0);
    chk("rst_audio_data", 32'(audio_data), 32'd0);
    chk("rst_audio_valid", 32'(audio_valid), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);

    // Forward playback from address 0, div=4.
    exp_addr.push_back(23'd0);
    exp_addr.push_back(23'd1);
    push_a(16'hAAAA, 0); push_a(16'hBBBB, 4); push_a(16'hAAAB, 4); push_a(16'hBBBA, 4);
    rst = 1'b0; play = 1'b1;
    wait_le(0, "fwd_timeout");
    play = 1'b0;
    step(4);

    // Reverse restart from END_ADDR, upper half first, then END_ADDR-1.
    exp_addr.push_back(END_A);
    exp_addr.push_back(END_M1);
    push_a(16'h4444, 0); push_a(16'h5555, 4); push_a(16'h4445, 4); push_a(16'h5554, 4);
    dir_fwd = 1'b0; restart = 1'b1; play = 1'b1;
    step(); restart = 1'b0;
    wait_le(0, "rev_timeout");
    play = 1'b0;
    step(4);

    // END_ADDR read, direction flips to forward mid-word: next address wraps to 0.
    exp_addr.push_back(END_A);
    exp_addr.push_back(23'd0);
    push_a(16'h4444, 0); push_a(16'h5555, 4); push_a(16'hAAAA, 4); push_a(16'hBBBB, 4);
    restart = 1'b1; play = 1'b1;
    step(); restart = 1'b0;
    wait_le(3, "wrap_first_timeout");
    dir_fwd = 1'b1;
    wait_le(0, "wrap_timeout");
    play = 1'b0;
    step(4);
    chk("no_underrun_steady", 32'(underrun), 32'd0);

    // Negative divider clamps to a tick per cycle; a 3-cycle stall underruns.
    exp_addr.push_back(23'd0);
    exp_addr.push_back(23'd1);
    push_a(16'hAAAA, 0); push_a(16'hBBBB, 1);
    div_clk_count = -32'sd5; stall_add += 3; restart = 1'b1; play = 1'b1;
    step(); restart = 1'b0;
    wait_le(0, "clamp_timeout");
    play = 1'b0;
    step(3);
    chk("underrun_set", 32'(underrun), 32'd1);
    restart = 1'b1;
    step(); restart = 1'b0;
    chk("underrun_cleared", 32'(underrun), 32'd0);
    chk("restart_idle_read", 32'(flash_read), 32'd0);
    chk("restart_idle_addr", 32'(flash_addr), 32'd0);
    chk("audio_data_held", 32'(audio_data), 32'h0000_BBBB);

    // Pause while the read is in flight; count resumes from where it froze.
    div_clk_count = 32'sd8;
    exp_addr.push_back(23'd0);
    exp_addr.push_back(23'd1);
    push_a(16'hAAAA, 0); push_a(16'hBBBB, 8);
    stall_add += 1; play = 1'b1;
    step(3); play = 1'b0;
    step(10);
    chk("pause_no_underrun", 32'(underrun), 32'd0);
    play = 1'b1;
    n = 0;
    while (!audio_valid && n < 50) begin
      step();
      n++;
    end
    chk("resume_latency", 32'(n), 32'd5);
    wait_le(0, "pause_timeout");
    play = 1'b0;
    step(4);

    // Restart during a stalled REQ: read held until accepted, word discarded, re-read at 0.
    exp_addr.push_back(23'd0);
    exp_addr.push_back(23'd0);
    push_a(16'hAAAA, 0); push_a(16'hBBBB, 8);
    stall_add += 5; poison_req++; restart = 1'b1; play = 1'b1;
    step(); restart = 1'b0;
    step(); restart = 1'b1;
    step(); restart = 1'b0;
    chk("req_read_high", 32'(flash_read), 32'd1);
    chk("req_addr_stable", 32'(flash_addr), 32'd0);
    step(3);
    chk("stall_read_high", 32'(flash_read), 32'd1);
    step();
    chk("read_dropped", 32'(flash_read), 32'd0);
    step();
    chk("rerequest_read", 32'(flash_read), 32'd1);
    wait_le(0, "restart_req_timeout");
    play = 1'b0;
    step(4);
    chk("restart_req_no_underrun", 32'(underrun), 32'd0);

    // Reset in the middle of a stalled read, then a stale data beat.
    stall_add += 20; dir_fwd = 1'b0; restart = 1'b1; play = 1'b1;
    step(); restart = 1'b0;
    step(2);
    chk("pre_rst_read", 32'(flash_read), 32'd1);
    chk("pre_rst_addr", 32'(flash_addr), 32'(END_A));
    rst = 1'b1; play = 1'b0;
    step();
    chk("mid_rst_read", 32'(flash_read), 32'd0);
    chk("mid_rst_addr", 32'(flash_addr), 32'd0);
    chk("mid_rst_audio_data", 32'(audio_data), 32'd0);
    chk("mid_rst_audio_valid", 32'(audio_valid), 32'd0);
    chk("mid_rst_underrun", 32'(underrun), 32'd0);
    rst = 1'b0; inj_req++;
    step(4);
    chk("stale_rdv_valid", 32'(audio_valid), 32'd0);
    chk("stale_rdv_read", 32'(flash_read), 32'd0);

    chk("audio_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("addr_queue_empty", 32'(exp_addr.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
